// File: rtl/mux8bit_8channel_rr_if.sv
// Bundle of the 8-to-1 merge datapath: eight valid/ready input channels,
// one valid/ready output channel with source tag, and the beat counter.
// slave: the multiplexer side; master: the producers/consumer side.
interface mux8bit_8channel_rr_if #(
    parameter int WIDTH = 8
);
    logic [7:0][WIDTH-1:0] data_in;     // per-channel payloads
    logic [7:0]            in_valid;    // per-channel beat present
    logic [7:0]            in_ready;    // per-channel beat accepted this cycle
    logic [WIDTH-1:0]      data_out;    // forwarded payload (registered)
    logic [2:0]            out_sel;     // source channel of data_out
    logic                  out_valid;   // data_out/out_sel hold a beat
    logic                  out_ready;   // consumer takes the beat
    logic [15:0]           beat_count;  // completed output handshakes

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_sel, out_valid, beat_count
    );

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_sel, out_valid, beat_count
    );
endinterface

// File: rtl/mux8bit_8channel_rr.sv
// Round-robin merge of eight valid/ready channels into one registered, tagged output.
// Latency: a beat accepted at edge N is presented on data_out/out_sel after edge N.
// Backpressure: while out_valid && !out_ready the output is frozen and in_ready is all 0.
// Ports: clk (rising edge), rst (async active-high), bus (slave modport:
//   data_in/in_valid/in_ready inputs side, data_out/out_sel/out_valid/out_ready
//   output side, beat_count total forwarded beats).
module mux8bit_8channel_rr #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    mux8bit_8channel_rr_if.slave         bus
);

    logic [WIDTH-1:0] data_out_q;
    logic [2:0]       out_sel_q;
    logic             out_valid_q;
    logic [2:0]       last_grant_q;
    logic [15:0]      beat_count_q;

    logic             load_en;
    logic             grant_found;
    logic [2:0]       grant_idx;
    logic [7:0]       grant;
    logic [7:0]       in_ready_d;
    logic             accept;
    logic             out_hs;

    // The holding register can take a new beat when empty or being drained.
    assign load_en = !out_valid_q || bus.out_ready;
    assign out_hs  = out_valid_q && bus.out_ready;

    // Scan from the channel after the last winner; k=8 wraps back onto the
    // last winner itself so it is only chosen when nobody else requests.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] idx;
            idx = last_grant_q + k[2:0];
            if (!grant_found && bus.in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        grant = 8'h00;
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Held off during reset so no producer believes a beat was taken.
    always_comb begin
        in_ready_d = 8'h00;
        if (load_en && !rst) begin
            in_ready_d = grant;
        end
    end

    assign accept = |(bus.in_valid & in_ready_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            out_sel_q    <= 3'd0;
            out_valid_q  <= 1'b0;
            last_grant_q <= 3'd7;
        end else if (accept) begin
            data_out_q   <= bus.data_in[grant_idx];
            out_sel_q    <= grant_idx;
            out_valid_q  <= 1'b1;
            last_grant_q <= grant_idx;
        end else if (out_hs) begin
            out_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count_q <= 16'h0000;
        end else if (out_hs) begin
            beat_count_q <= beat_count_q + 16'h0001;
        end
    end

    assign bus.in_ready   = in_ready_d;
    assign bus.data_out   = data_out_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.beat_count = beat_count_q;

endmodule

// File: tb/tb_mux8bit_8channel_rr.sv
// Directed bench for the round-robin 8-to-1 merge.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Each scenario task carries its own hand-computed expectations.
module tb_mux8bit_8channel_rr;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux8bit_8channel_rr_if #(.WIDTH(8)) bus ();

    mux8bit_8channel_rr #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_all_data(input logic [7:0] base);
        for (int i = 0; i < 8; i++) bus.data_in[i] = base + 8'(i);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        bus.in_valid  = 8'h00;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        set_all_data(8'h40);
        settle();
        step();
        checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready: got %h want 00", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
        checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL reset_out_sel: got %0d want 0", bus.out_sel); end
        checks++; if (bus.beat_count !== 16'h0000) begin errors++; $display("FAIL reset_beat_count: got %h want 0000", bus.beat_count); end
        rst = 1'b0;
        settle();
        checks++; if (bus.in_ready !== 8'h01) begin errors++; $display("FAIL release_in_ready: got %h want 01", bus.in_ready); end
        bus.in_valid = 8'h00;
    endtask

    task automatic test_single_channel();
        do_reset();
        bus.data_in[3] = 8'hA5;
        bus.in_valid   = 8'h08;
        bus.out_ready  = 1'b1;
        settle();
        checks++; if (bus.in_ready !== 8'h08) begin errors++; $display("FAIL single_in_ready: got %h want 08", bus.in_ready); end
        step();
        bus.in_valid = 8'h00;
        settle();
        checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL single_data_out: got %h want a5", bus.data_out); end
        checks++; if (bus.out_sel !== 3'd3) begin errors++; $display("FAIL single_out_sel: got %0d want 3", bus.out_sel); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL single_in_ready_after: got %h want 00", bus.in_ready); end
        step();
        checks++; if (bus.beat_count !== 16'h0001) begin errors++; $display("FAIL single_beat_count: got %h want 0001", bus.beat_count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_sel;
        do_reset();
        set_all_data(8'h10);
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            step();
            exp_sel = 3'(n % 8);
            checks++; if (bus.out_sel !== exp_sel || bus.data_out !== (8'h10 + 8'(exp_sel)) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_beat%0d: got sel=%0d data=%h vld=%b want sel=%0d data=%h vld=1",
                         n, bus.out_sel, bus.data_out, bus.out_valid, exp_sel, 8'h10 + 8'(exp_sel));
            end
        end
        bus.in_valid = 8'h00;
        step();
        checks++; if (bus.beat_count !== 16'd16) begin errors++; $display("FAIL rr_beat_count: got %0d want 16", bus.beat_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_all_data(8'h10);
        bus.data_in[5] = 8'h3C;
        bus.in_valid   = 8'h20;
        bus.out_ready  = 1'b0;
        step();
        bus.in_valid = 8'hFF;
        for (int n = 0; n < 10; n++) begin
            settle();
            checks++; if (bus.data_out !== 8'h3C || bus.out_sel !== 3'd5 || bus.out_valid !== 1'b1 || bus.in_ready !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold%0d: got data=%h sel=%0d vld=%b rdy=%h want data=3c sel=5 vld=1 rdy=00",
                         n, bus.data_out, bus.out_sel, bus.out_valid, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        settle();
        checks++; if (bus.in_ready !== 8'h40) begin errors++; $display("FAIL bp_release_in_ready: got %h want 40", bus.in_ready); end
        step();
        checks++; if (bus.out_sel !== 3'd6 || bus.data_out !== 8'h16) begin
            errors++; $display("FAIL bp_next_beat: got sel=%0d data=%h want sel=6 data=16", bus.out_sel, bus.data_out);
        end
        checks++; if (bus.beat_count !== 16'd1) begin errors++; $display("FAIL bp_beat_count: got %0d want 1", bus.beat_count); end
        bus.in_valid = 8'h00;
        step();
    endtask

    task automatic test_fairness_skip();
        logic [2:0] exp_sel [4];
        exp_sel[0] = 3'd0; exp_sel[1] = 3'd7; exp_sel[2] = 3'd0; exp_sel[3] = 3'd7;
        do_reset();
        bus.data_in[0] = 8'hA0;
        bus.data_in[7] = 8'hA7;
        bus.in_valid   = 8'h81;
        bus.out_ready  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (bus.out_sel !== exp_sel[n] || bus.data_out !== ((exp_sel[n] == 3'd0) ? 8'hA0 : 8'hA7)) begin
                errors++;
                $display("FAIL skip_beat%0d: got sel=%0d data=%h want sel=%0d", n, bus.out_sel, bus.data_out, exp_sel[n]);
            end
        end
        bus.in_valid = 8'h00;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_all_data(8'h50);
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        step(); step(); step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd2) begin
            errors++; $display("FAIL mid_pre: got vld=%b sel=%0d want vld=1 sel=2", bus.out_valid, bus.out_sel);
        end
        rst = 1'b1;
        settle();
        checks++; if (bus.out_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.beat_count !== 16'h0000) begin
            errors++; $display("FAIL mid_async: got vld=%b data=%h cnt=%h want vld=0 data=00 cnt=0000",
                               bus.out_valid, bus.data_out, bus.beat_count);
        end
        step();
        rst = 1'b0;
        settle();
        checks++; if (bus.in_ready !== 8'h01) begin errors++; $display("FAIL mid_restart_rdy: got %h want 01", bus.in_ready); end
        step();
        checks++; if (bus.out_sel !== 3'd0 || bus.data_out !== 8'h50) begin
            errors++; $display("FAIL mid_restart_beat: got sel=%0d data=%h want sel=0 data=50", bus.out_sel, bus.data_out);
        end
        bus.in_valid = 8'h00;
        step();
    endtask

    task automatic test_wrap();
        int budget;
        do_reset();
        set_all_data(8'h60);
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        budget = 0;
        while (bus.beat_count !== 16'hFFFF && budget < 70000) begin
            step();
            budget++;
        end
        checks++; if (bus.beat_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_reach: got %h want ffff (timeout)", bus.beat_count); end
        step();
        checks++; if (bus.beat_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bus.beat_count); end
        bus.in_valid = 8'h00;
        step();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.in_valid  = 8'h00;
        bus.out_ready = 1'b0;
        set_all_data(8'h00);
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_fairness_skip();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
